// File: rtl/uart_cal_pkg.sv
// Frame format shared by the command decoder and the result encoder:
// start-of-frame byte, dtype codes, payload length rule and FSM states.
package uart_cal_pkg;

  localparam logic [7:0] SOF = 8'hA5;

  localparam logic [3:0] DT_8  = 4'd0;
  localparam logic [3:0] DT_16 = 4'd1;
  localparam logic [3:0] DT_32 = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_HDR,
    ST_PAY,
    ST_CHK
  } state_t;

  // Payload length in bytes; unknown dtype codes fall back to a full word.
  function automatic logic [3:0] len_of_dtype(input logic [3:0] dt);
    case (dt)
      DT_8:    return 4'd1;
      DT_16:   return 4'd2;
      default: return 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/result_encoder.sv
// Frames a result as SOF, header, MSB-first payload, checksum and hands the
// bytes one by one to the UART transmitter over a valid/ready handshake.
module result_encoder #(
  parameter logic [7:0] SOF    = uart_cal_pkg::SOF,
  parameter int         DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        dtype,
  input  logic [DATA_W-1:0] result,
  output logic              busy,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done,
  output logic              drop
);

  import uart_cal_pkg::*;

  state_t            state_reg;
  logic [3:0]        dtype_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [3:0]        count_reg;      // payload bytes still to load after the one on tx_data
  logic [7:0]        checksum_reg;   // XOR of every byte loaded so far, SOF excluded

  logic [3:0]        start_len;
  logic [DATA_W-1:0] aligned_result;
  logic [7:0]        header_byte;
  logic [7:0]        top_byte;
  logic              handshake;

  // Capture-side helpers: short results are pushed up to the MSB so the
  // payload always leaves from the top byte of the shift register.
  always_comb begin
    start_len      = len_of_dtype(dtype);
    aligned_result = result << (DATA_W - 8 * int'(start_len));
    header_byte    = {dtype_reg, len_of_dtype(dtype_reg)};
    top_byte       = shift_reg[DATA_W-1 -: 8];
    handshake      = tx_valid && tx_ready;
  end

  // Frame FSM with registered outputs; every state advance waits for a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      dtype_reg    <= '0;
      shift_reg    <= '0;
      count_reg    <= '0;
      checksum_reg <= '0;
      busy         <= 1'b0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      done         <= 1'b0;
      drop         <= 1'b0;
    end else begin
      done <= 1'b0;
      drop <= start && busy;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            dtype_reg    <= dtype;
            shift_reg    <= aligned_result;
            count_reg    <= start_len;
            checksum_reg <= '0;
            tx_data      <= SOF;
            tx_valid     <= 1'b1;
            busy         <= 1'b1;
            state_reg    <= ST_SOF;
          end
        end
        ST_SOF: begin
          if (handshake) begin
            tx_data      <= header_byte;
            checksum_reg <= checksum_reg ^ header_byte;
            state_reg    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (handshake) begin
            tx_data      <= top_byte;
            checksum_reg <= checksum_reg ^ top_byte;
            shift_reg    <= shift_reg << 8;
            count_reg    <= count_reg - 4'd1;
            state_reg    <= ST_PAY;
          end
        end
        ST_PAY: begin
          if (handshake) begin
            if (count_reg == 4'd0) begin
              tx_data   <= checksum_reg;
              state_reg <= ST_CHK;
            end else begin
              tx_data      <= top_byte;
              checksum_reg <= checksum_reg ^ top_byte;
              shift_reg    <= shift_reg << 8;
              count_reg    <= count_reg - 4'd1;
            end
          end
        end
        ST_CHK: begin
          if (handshake) begin
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_valid  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
